axi4_mem_arbiter: RTL

Two-master to one-slave AXI4 arbiter that shares the RocketChip 64-bit memory port's DDR slave between the core (S0) and a second master such as DMA or a debug loader (S1). It sits between the chip wrapper's `M_AXI_*` memory bus and the memory controller. Read and write address channels are arbitrated independently, round-robin. Responses are routed back by a source bit prepended to the AXI ID.

---
 rtl/axi4_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_mem_arbiter.sv
// Two-master to one-slave AXI4 arbiter: round-robin AR/AW grants, source bit prepended to IDs,
// and a write-order queue that steers the W channel in AW acceptance order.
module axi4_mem_arbiter #(
    parameter int ID_W     = 5,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int WQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    // slave port 0 (core)
    input  logic [ID_W-1:0]     S0_AXI_awid,
    input  logic [ADDR_W-1:0]   S0_AXI_awaddr,
    input  logic [7:0]          S0_AXI_awlen,
    input  logic [2:0]          S0_AXI_awsize,
    input  logic [1:0]          S0_AXI_awburst,
    input  logic                S0_AXI_awlock,
    input  logic [3:0]          S0_AXI_awcache,
    input  logic [2:0]          S0_AXI_awprot,
    input  logic [3:0]          S0_AXI_awqos,
    input  logic                S0_AXI_awvalid,
    output logic                S0_AXI_awready,
    input  logic [DATA_W-1:0]   S0_AXI_wdata,
    input  logic [DATA_W/8-1:0] S0_AXI_wstrb,
    input  logic                S0_AXI_wlast,
    input  logic                S0_AXI_wvalid,
    output logic                S0_AXI_wready,
    output logic [ID_W-1:0]     S0_AXI_bid,
    output logic [1:0]          S0_AXI_bresp,
    output logic                S0_AXI_bvalid,
    input  logic                S0_AXI_bready,
    input  logic [ID_W-1:0]     S0_AXI_arid,
    input  logic [ADDR_W-1:0]   S0_AXI_araddr,
    input  logic [7:0]          S0_AXI_arlen,
    input  logic [2:0]          S0_AXI_arsize,
    input  logic [1:0]          S0_AXI_arburst,
    input  logic                S0_AXI_arlock,
    input  logic [3:0]          S0_AXI_arcache,
    input  logic [2:0]          S0_AXI_arprot,
    input  logic [3:0]          S0_AXI_arqos,
    input  logic                S0_AXI_arvalid,
    output logic                S0_AXI_arready,
    output logic [ID_W-1:0]     S0_AXI_rid,
    output logic [DATA_W-1:0]   S0_AXI_rdata,
    output logic [1:0]          S0_AXI_rresp,
    output logic                S0_AXI_rlast,
    output logic                S0_AXI_rvalid,
    input  logic                S0_AXI_rready,
    // slave port 1
    input  logic [ID_W-1:0]     S1_AXI_awid,
    input  logic [ADDR_W-1:0]   S1_AXI_awaddr,
    input  logic [7:0]          S1_AXI_awlen,
    input  logic [2:0]          S1_AXI_awsize,
    input  logic [1:0]          S1_AXI_awburst,
    input  logic                S1_AXI_awlock,
    input  logic [3:0]          S1_AXI_awcache,
    input  logic [2:0]          S1_AXI_awprot,
    input  logic [3:0]          S1_AXI_awqos,
    input  logic                S1_AXI_awvalid,
    output logic                S1_AXI_awready,
    input  logic [DATA_W-1:0]   S1_AXI_wdata,
    input  logic [DATA_W/8-1:0] S1_AXI_wstrb,
    input  logic                S1_AXI_wlast,
    input  logic                S1_AXI_wvalid,
    output logic                S1_AXI_wready,
    output logic [ID_W-1:0]     S1_AXI_bid,
    output logic [1:0]          S1_AXI_bresp,
    output logic                S1_AXI_bvalid,
    input  logic                S1_AXI_bready,
    input  logic [ID_W-1:0]     S1_AXI_arid,
    input  logic [ADDR_W-1:0]   S1_AXI_araddr,
    input  logic [7:0]          S1_AXI_arlen,
    input  logic [2:0]          S1_AXI_arsize,
    input  logic [1:0]          S1_AXI_arburst,
    input  logic                S1_AXI_arlock,
    input  logic [3:0]          S1_AXI_arcache,
    input  logic [2:0]          S1_AXI_arprot,
    input  logic [3:0]          S1_AXI_arqos,
    input  logic                S1_AXI_arvalid,
    output logic                S1_AXI_arready,
    output logic [ID_W-1:0]     S1_AXI_rid,
    output logic [DATA_W-1:0]   S1_AXI_rdata,
    output logic [1:0]          S1_AXI_rresp,
    output logic                S1_AXI_rlast,
    output logic                S1_AXI_rvalid,
    input  logic                S1_AXI_rready,
    // master port to the memory controller
    output logic [ID_W:0]       M_AXI_awid,
    output logic [ADDR_W-1:0]   M_AXI_awaddr,
    output logic [7:0]          M_AXI_awlen,
    output logic [2:0]          M_AXI_awsize,
    output logic [1:0]          M_AXI_awburst,
    output logic                M_AXI_awlock,
    output logic [3:0]          M_AXI_awcache,
    output logic [2:0]          M_AXI_awprot,
    output logic [3:0]          M_AXI_awqos,
    output logic                M_AXI_awvalid,
    input  logic                M_AXI_awready,
    output logic [DATA_W-1:0]   M_AXI_wdata,
    output logic [DATA_W/8-1:0] M_AXI_wstrb,
    output logic                M_AXI_wlast,
    output logic                M_AXI_wvalid,
    input  logic                M_AXI_wready,
    input  logic [ID_W:0]       M_AXI_bid,
    input  logic [1:0]          M_AXI_bresp,
    input  logic                M_AXI_bvalid,
    output logic                M_AXI_bready,
    output logic [ID_W:0]       M_AXI_arid,
    output logic [ADDR_W-1:0]   M_AXI_araddr,
    output logic [7:0]          M_AXI_arlen,
    output logic [2:0]          M_AXI_arsize,
    output logic [1:0]          M_AXI_arburst,
    output logic                M_AXI_arlock,
    output logic [3:0]          M_AXI_arcache,
    output logic [2:0]          M_AXI_arprot,
    output logic [3:0]          M_AXI_arqos,
    output logic                M_AXI_arvalid,
    input  logic                M_AXI_arready,
    input  logic [ID_W:0]       M_AXI_rid,
    input  logic [DATA_W-1:0]   M_AXI_rdata,
    input  logic [1:0]          M_AXI_rresp,
    input  logic                M_AXI_rlast,
    input  logic                M_AXI_rvalid,
    output logic                M_AXI_rready
);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    arb_state_t ar_state, ar_state_nxt, aw_state, aw_state_nxt;
    logic ar_gnt_held, ar_gnt_held_nxt, rr_ar, rr_ar_nxt, ar_sel, ar_req, ar_hs;
    logic aw_gnt_held, aw_gnt_held_nxt, rr_aw, rr_aw_nxt, aw_sel, aw_req, aw_hs;

    logic [WQ_DEPTH-1:0] wq_mem;
    logic [PTR_W-1:0]    wq_wr_ptr, wq_rd_ptr;
    logic [CNT_W-1:0]    wq_cnt;
    logic wq_full, wq_empty, wq_head, wq_push, wq_pop, w_vld;

    always_comb begin
        ar_sel          = ar_gnt_held;
        ar_state_nxt    = ar_state;
        ar_gnt_held_nxt = ar_gnt_held;
        rr_ar_nxt       = rr_ar;
        if (ar_state == ARB_IDLE)
            ar_sel = (S0_AXI_arvalid && S1_AXI_arvalid) ? rr_ar : S1_AXI_arvalid;
        ar_req = ar_sel ? S1_AXI_arvalid : S0_AXI_arvalid;
        ar_hs  = ar_req && M_AXI_arready;
        if (ar_hs) begin
            ar_state_nxt = ARB_IDLE;
            rr_ar_nxt    = ~ar_sel;
        end else if (ar_req) begin
            // freeze the grant so the presented address cannot change before ready
            ar_state_nxt    = ARB_LOCKED;
            ar_gnt_held_nxt = ar_sel;
        end
    end

    always_comb begin
        aw_sel          = aw_gnt_held;
        aw_state_nxt    = aw_state;
        aw_gnt_held_nxt = aw_gnt_held;
        rr_aw_nxt       = rr_aw;
        if (aw_state == ARB_IDLE)
            aw_sel = (S0_AXI_awvalid && S1_AXI_awvalid) ? rr_aw : S1_AXI_awvalid;
        // fullness only gates a fresh grant; a locked grant already owns a queue slot
        aw_req = (aw_state == ARB_IDLE && wq_full) ? 1'b0
                                                    : (aw_sel ? S1_AXI_awvalid : S0_AXI_awvalid);
        aw_hs  = aw_req && M_AXI_awready;
        if (aw_hs) begin
            aw_state_nxt = ARB_IDLE;
            rr_aw_nxt    = ~aw_sel;
        end else if (aw_req) begin
            aw_state_nxt    = ARB_LOCKED;
            aw_gnt_held_nxt = aw_sel;
        end
    end

    assign wq_full  = (wq_cnt == CNT_W'(WQ_DEPTH));
    assign wq_empty = (wq_cnt == '0);
    assign wq_head  = wq_mem[wq_rd_ptr];
    assign wq_push  = aw_hs;
    assign w_vld    = !wq_empty && (wq_head ? S1_AXI_wvalid : S0_AXI_wvalid);
    assign wq_pop   = w_vld && M_AXI_wready && M_AXI_wlast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_state    <= ARB_IDLE;
            ar_gnt_held <= 1'b0;
            rr_ar       <= 1'b0;
            aw_state    <= ARB_IDLE;
            aw_gnt_held <= 1'b0;
            rr_aw       <= 1'b0;
            wq_wr_ptr   <= '0;
            wq_rd_ptr   <= '0;
            wq_cnt      <= '0;
        end else begin
            ar_state    <= ar_state_nxt;
            ar_gnt_held <= ar_gnt_held_nxt;
            rr_ar       <= rr_ar_nxt;
            aw_state    <= aw_state_nxt;
            aw_gnt_held <= aw_gnt_held_nxt;
            rr_aw       <= rr_aw_nxt;
            if (wq_push) wq_wr_ptr <= wq_wr_ptr + PTR_W'(1);
            if (wq_pop)  wq_rd_ptr <= wq_rd_ptr + PTR_W'(1);
            case ({wq_push, wq_pop})
                2'b10:   wq_cnt <= wq_cnt + CNT_W'(1);
                2'b01:   wq_cnt <= wq_cnt - CNT_W'(1);
                default: wq_cnt <= wq_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wq_push) wq_mem[wq_wr_ptr] <= aw_sel;
    end

    // address channels: payload follows the grant, handshakes are gated off during reset
    assign M_AXI_arvalid  = ar_req && !reset;
    assign S0_AXI_arready = !reset && !ar_sel && ar_req && M_AXI_arready;
    assign S1_AXI_arready = !reset &&  ar_sel && ar_req && M_AXI_arready;
    assign M_AXI_arid     = {ar_sel, ar_sel ? S1_AXI_arid : S0_AXI_arid};
    assign M_AXI_araddr   = ar_sel ? S1_AXI_araddr  : S0_AXI_araddr;
    assign M_AXI_arlen    = ar_sel ? S1_AXI_arlen   : S0_AXI_arlen;
    assign M_AXI_arsize   = ar_sel ? S1_AXI_arsize  : S0_AXI_arsize;
    assign M_AXI_arburst  = ar_sel ? S1_AXI_arburst : S0_AXI_arburst;
    assign M_AXI_arlock   = ar_sel ? S1_AXI_arlock  : S0_AXI_arlock;
    assign M_AXI_arcache  = ar_sel ? S1_AXI_arcache : S0_AXI_arcache;
    assign M_AXI_arprot   = ar_sel ? S1_AXI_arprot  : S0_AXI_arprot;
    assign M_AXI_arqos    = ar_sel ? S1_AXI_arqos   : S0_AXI_arqos;

    assign M_AXI_awvalid  = aw_req && !reset;
    assign S0_AXI_awready = !reset && !aw_sel && aw_req && M_AXI_awready;
    assign S1_AXI_awready = !reset &&  aw_sel && aw_req && M_AXI_awready;
    assign M_AXI_awid     = {aw_sel, aw_sel ? S1_AXI_awid : S0_AXI_awid};
    assign M_AXI_awaddr   = aw_sel ? S1_AXI_awaddr  : S0_AXI_awaddr;
    assign M_AXI_awlen    = aw_sel ? S1_AXI_awlen   : S0_AXI_awlen;
    assign M_AXI_awsize   = aw_sel ? S1_AXI_awsize  : S0_AXI_awsize;
    assign M_AXI_awburst  = aw_sel ? S1_AXI_awburst : S0_AXI_awburst;
    assign M_AXI_awlock   = aw_sel ? S1_AXI_awlock  : S0_AXI_awlock;
    assign M_AXI_awcache  = aw_sel ? S1_AXI_awcache : S0_AXI_awcache;
    assign M_AXI_awprot   = aw_sel ? S1_AXI_awprot  : S0_AXI_awprot;
    assign M_AXI_awqos    = aw_sel ? S1_AXI_awqos   : S0_AXI_awqos;

    assign M_AXI_wvalid   = w_vld && !reset;
    assign M_AXI_wdata    = wq_head ? S1_AXI_wdata : S0_AXI_wdata;
    assign M_AXI_wstrb    = wq_head ? S1_AXI_wstrb : S0_AXI_wstrb;
    assign M_AXI_wlast    = wq_head ? S1_AXI_wlast : S0_AXI_wlast;
    assign S0_AXI_wready  = !reset && !wq_empty && !wq_head && M_AXI_wready;
    assign S1_AXI_wready  = !reset && !wq_empty &&  wq_head && M_AXI_wready;

    // responses are steered by the source bit on top of the returned ID
    assign S0_AXI_rvalid  = !reset && M_AXI_rvalid && !M_AXI_rid[ID_W];
    assign S1_AXI_rvalid  = !reset && M_AXI_rvalid &&  M_AXI_rid[ID_W];
    assign M_AXI_rready   = !reset && (M_AXI_rid[ID_W] ? S1_AXI_rready : S0_AXI_rready);
    assign S0_AXI_rid     = M_AXI_rid[ID_W-1:0];
    assign S1_AXI_rid     = M_AXI_rid[ID_W-1:0];
    assign S0_AXI_rdata   = M_AXI_rdata;
    assign S1_AXI_rdata   = M_AXI_rdata;
    assign S0_AXI_rresp   = M_AXI_rresp;
    assign S1_AXI_rresp   = M_AXI_rresp;
    assign S0_AXI_rlast   = M_AXI_rlast;
    assign S1_AXI_rlast   = M_AXI_rlast;

    assign S0_AXI_bvalid  = !reset && M_AXI_bvalid && !M_AXI_bid[ID_W];
    assign S1_AXI_bvalid  = !reset && M_AXI_bvalid &&  M_AXI_bid[ID_W];
    assign M_AXI_bready   = !reset && (M_AXI_bid[ID_W] ? S1_AXI_bready : S0_AXI_bready);
    assign S0_AXI_bid     = M_AXI_bid[ID_W-1:0];
    assign S1_AXI_bid     = M_AXI_bid[ID_W-1:0];
    assign S0_AXI_bresp   = M_AXI_bresp;
    assign S1_AXI_bresp   = M_AXI_bresp;
endmodule
